// File: rtl/simon_pkg.sv
// Shared constants and state encoding for the Simon128/256 key schedule.
// Z4 is stored so that the leftmost published bit is bit 61 (index 0 of the sequence).
package simon_pkg;

  localparam int WORD_W    = 64;
  localparam int KEY_WORDS = 4;
  localparam int ROUNDS    = 72;
  localparam int Z_LEN     = 62;

  localparam logic [Z_LEN-1:0] Z4 =
    62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    DONE
  } key_state_t;

endpackage

// File: rtl/simon_key_round.sv
// One Simon key-schedule step (m=4): k[i] = ~k[i-4] ^ t ^ ROR1(t) ^ z ^ 3, with t = ROR3(k[i-1]) ^ k[i-3].
// Purely combinational.
module simon_key_round #(
  parameter int WORD_W = 64
) (
  input  logic [WORD_W-1:0] k_im4,
  input  logic [WORD_W-1:0] k_im3,
  input  logic [WORD_W-1:0] k_im1,
  input  logic              z,
  output logic [WORD_W-1:0] k_i
);

  logic [WORD_W-1:0] t;

  always_comb begin
    t   = {k_im1[2:0], k_im1[WORD_W-1:3]} ^ k_im3;
    k_i = ~k_im4 ^ t ^ {t[0], t[WORD_W-1:1]} ^ WORD_W'(3) ^ WORD_W'(z);
  end

endmodule

// File: rtl/simon_key_expand.sv
// Simon128/256 key expansion: streams ROUNDS round keys, one per cycle, on a write port after a start.
// Optional rk_wr_par output (even parity of rk_wr_data) when SIMON_KEY_PARITY_EN is defined.
module simon_key_expand #(
  parameter int WORD_W    = simon_pkg::WORD_W,
  parameter int KEY_WORDS = simon_pkg::KEY_WORDS,
  parameter int ROUNDS    = simon_pkg::ROUNDS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WORD_W*KEY_WORDS-1:0] init_key,
  input  logic                        key_compute_start,
  output logic                        rk_wr_en,
  output logic [6:0]                  rk_wr_addr,
  output logic [WORD_W-1:0]           rk_wr_data,
  output logic                        key_busy,
  output logic                        key_ready
`ifdef SIMON_KEY_PARITY_EN
  ,
  output logic                        rk_wr_par
`endif
);

  import simon_pkg::*;

  localparam int WIN_AW = $clog2(KEY_WORDS);

  key_state_t        state;
  key_state_t        state_nxt;
  logic [WORD_W-1:0] win [KEY_WORDS];
  logic [6:0]        idx;
  logic [5:0]        zi;
  logic              z_bit;
  logic              load;
  logic              emit;
  logic              shift;
  logic              finish;
  logic [WORD_W-1:0] k_new;
  logic [WORD_W-1:0] emit_dat;
  logic [WORD_W-1:0] data_nxt;

  // win[j] holds k[idx-KEY_WORDS+j] once expansion is under way.
  assign z_bit = Z4[6'(Z_LEN-1) - zi];

  simon_key_round #(.WORD_W(WORD_W)) u_round (
    .k_im4 (win[0]),
    .k_im3 (win[KEY_WORDS-3]),
    .k_im1 (win[KEY_WORDS-1]),
    .z     (z_bit),
    .k_i   (k_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    emit      = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (key_compute_start) begin
          state_nxt = LOAD;
          load      = 1'b1;
        end
      end
      LOAD: begin
        emit = 1'b1;
        if (idx == 7'(KEY_WORDS)) begin
          shift     = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (idx == 7'(ROUNDS)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          emit  = 1'b1;
          shift = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Initial words are replayed from the window; later words come from the round function.
  always_comb begin
    emit_dat = (idx < 7'(KEY_WORDS)) ? win[idx[WIN_AW-1:0]] : k_new;
    data_nxt = load ? init_key[WORD_W-1:0] : emit_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < KEY_WORDS; j++) win[j] <= '0;
      idx        <= '0;
      zi         <= '0;
      rk_wr_en   <= 1'b0;
      rk_wr_addr <= '0;
      rk_wr_data <= '0;
      key_busy   <= 1'b0;
      key_ready  <= 1'b0;
    end else if (load) begin
      for (int j = 0; j < KEY_WORDS; j++) win[j] <= init_key[j*WORD_W +: WORD_W];
      idx        <= 7'd1;
      zi         <= '0;
      rk_wr_en   <= 1'b1;
      rk_wr_addr <= '0;
      rk_wr_data <= data_nxt;
      key_busy   <= 1'b1;
      key_ready  <= 1'b0;
    end else if (emit) begin
      rk_wr_en   <= 1'b1;
      rk_wr_addr <= idx;
      rk_wr_data <= data_nxt;
      idx        <= idx + 7'd1;
      if (shift) begin
        for (int j = 0; j < KEY_WORDS-1; j++) win[j] <= win[j+1];
        win[KEY_WORDS-1] <= k_new;
        zi <= (zi == 6'(Z_LEN-1)) ? 6'd0 : zi + 6'd1;
      end
    end else begin
      rk_wr_en <= 1'b0;
      if (finish) begin
        key_busy  <= 1'b0;
        key_ready <= 1'b1;
      end
    end
  end

`ifdef SIMON_KEY_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           rk_wr_par <= 1'b0;
    else if (load | emit) rk_wr_par <= ^data_nxt;
  end
`endif

endmodule

// File: tb/tb_simon_key_expand.sv
// Directed bench for simon_key_expand: reset, Simon128/256 vector, latency, busy-ignore, z wrap, back-to-back, parity.
module tb_simon_key_expand;

  localparam logic [61:0]  Z4B     = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [255:0] VEC_KEY = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [255:0] init_key = '0;
  logic         rk_wr_en;
  logic [6:0]   rk_wr_addr;
  logic [63:0]  rk_wr_data;
  logic         key_busy;
  logic         key_ready;
`ifdef SIMON_KEY_PARITY_EN
  logic         rk_wr_par;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_k [72];
  logic [63:0] got_k [72];

  simon_key_expand dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .init_key          (init_key),
    .key_compute_start (start),
    .rk_wr_en          (rk_wr_en),
    .rk_wr_addr        (rk_wr_addr),
    .rk_wr_data        (rk_wr_data),
    .key_busy          (key_busy),
    .key_ready         (key_ready)
`ifdef SIMON_KEY_PARITY_EN
    ,
    .rk_wr_par         (rk_wr_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference key schedule written straight from the Simon definition.
  function automatic void build_model(input logic [255:0] key);
    logic [63:0] t;
    for (int i = 0; i < 4; i++) exp_k[i] = key[64*i +: 64];
    for (int i = 4; i < 72; i++) begin
      t = {exp_k[i-1][2:0], exp_k[i-1][63:3]} ^ exp_k[i-3];
      exp_k[i] = ~exp_k[i-4] ^ t ^ {t[0], t[63:1]} ^ 64'd3 ^ {63'd0, Z4B[61 - ((i-4) % 62)]};
    end
  endfunction

  // Start at edge T, then sample cycles T+1..T+73 on the falling edge.
  task automatic run_key(input logic [255:0] key, input int inject_at, input bit hold, input string tag);
    int pulses;
    pulses = 0;
    build_model(key);
    @(negedge clk);
    init_key = key;
    start    = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 73; c++) begin
      @(negedge clk);
      if (rk_wr_en) pulses++;
      if (c == 1) begin
        chk({tag, "_busy_T1"}, 64'(key_busy), 64'd1);
        chk({tag, "_ready_T1"}, 64'(key_ready), 64'd0);
      end
      if (c <= 72) begin
        got_k[c-1] = rk_wr_data;
        chk($sformatf("%s_en%0d", tag, c-1), 64'(rk_wr_en), 64'd1);
        chk($sformatf("%s_addr%0d", tag, c-1), 64'(rk_wr_addr), 64'(c-1));
        chk($sformatf("%s_data%0d", tag, c-1), rk_wr_data, exp_k[c-1]);
`ifdef SIMON_KEY_PARITY_EN
        chk($sformatf("%s_par%0d", tag, c-1), 64'(rk_wr_par), 64'(^exp_k[c-1]));
`endif
      end else begin
        chk({tag, "_en_T73"}, 64'(rk_wr_en), 64'd0);
        chk({tag, "_busy_T73"}, 64'(key_busy), 64'd0);
        chk({tag, "_ready_T73"}, 64'(key_ready), 64'd1);
      end
      start    = hold || (c == inject_at);
      init_key = (c == inject_at) ? ~key : key;
    end
    chk({tag, "_pulses"}, 64'(pulses), 64'd72);
  endtask

  initial begin
    int pulses;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_en", 64'(rk_wr_en), 64'd0);
    chk("rst_addr", 64'(rk_wr_addr), 64'd0);
    chk("rst_data", rk_wr_data, 64'd0);
    chk("rst_busy", 64'(key_busy), 64'd0);
    chk("rst_ready", 64'(key_ready), 64'd0);
`ifdef SIMON_KEY_PARITY_EN
    chk("rst_par", 64'(rk_wr_par), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_en", 64'(rk_wr_en), 64'd0);

    run_key(VEC_KEY, 0, 1'b0, "vec");
    chk("vec_addr0_const", got_k[0], 64'h0706050403020100);
    chk("vec_addr3_const", got_k[3], 64'h1f1e1d1c1b1a1918);

    // Outputs must hold their last values while idle in DONE.
    repeat (3) begin
      @(negedge clk);
      chk("hold_en", 64'(rk_wr_en), 64'd0);
      chk("hold_addr", 64'(rk_wr_addr), 64'd71);
      chk("hold_data", rk_wr_data, exp_k[71]);
      chk("hold_ready", 64'(key_ready), 64'd1);
    end

    run_key(256'd0, 0, 1'b0, "zero");
    chk("zero_k4_hand", got_k[4], 64'hfffffffffffffffd);
    chk("zero_k5_hand", got_k[5], 64'h9ffffffffffffffd);
    chk("zwrap_addr66", got_k[66], exp_k[66]);

    run_key(VEC_KEY, 10, 1'b0, "ign");

    // Start held through DONE: one DONE cycle, then a fresh expansion.
    run_key(VEC_KEY, 0, 1'b1, "b2b");
    @(negedge clk);
    chk("b2b_restart_en", 64'(rk_wr_en), 64'd1);
    chk("b2b_restart_addr", 64'(rk_wr_addr), 64'd0);
    chk("b2b_restart_data", rk_wr_data, 64'h0706050403020100);
    chk("b2b_restart_ready", 64'(key_ready), 64'd0);
    chk("b2b_restart_busy", 64'(key_busy), 64'd1);
    start = 1'b0;

    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_en", 64'(rk_wr_en), 64'd0);
    chk("arst_addr", 64'(rk_wr_addr), 64'd0);
    chk("arst_data", rk_wr_data, 64'd0);
    chk("arst_busy", 64'(key_busy), 64'd0);
    chk("arst_ready", 64'(key_ready), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rk_wr_en) pulses++;
    end
    chk("post_rst_pulses", 64'(pulses), 64'd0);
    chk("post_rst_busy", 64'(key_busy), 64'd0);
    chk("post_rst_ready", 64'(key_ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
